// File: rtl/spm_arbiter_if.sv
// Bundle of the two requester ports and the SPM port of spm_arbiter.
// slave = arbiter side; master = the requesters together with the SPM macro.
`timescale 1ns/1ps
interface spm_arbiter_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);
  // IF requester (read-only)
  logic              if_as_;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rd_data;
  logic              if_rdy;
  logic              if_busy;

  // MEM requester (read/write)
  logic              mem_as_;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rdy;
  logic              mem_busy;

  // single-port SPM, one-cycle synchronous read
  logic [ADDR_W-1:0] spm_addr;
  logic              spm_as_;
  logic              spm_rw;
  logic [DATA_W-1:0] spm_wr_data;
  logic [DATA_W-1:0] spm_rd_data;

  modport slave (
    input  if_as_, if_addr,
    output if_rd_data, if_rdy, if_busy,
    input  mem_as_, mem_addr, mem_rw, mem_wr_data,
    output mem_rd_data, mem_rdy, mem_busy,
    output spm_addr, spm_as_, spm_rw, spm_wr_data,
    input  spm_rd_data
  );

  modport master (
    output if_as_, if_addr,
    input  if_rd_data, if_rdy, if_busy,
    output mem_as_, mem_addr, mem_rw, mem_wr_data,
    input  mem_rd_data, mem_rdy, mem_busy,
    input  spm_addr, spm_as_, spm_rw, spm_wr_data,
    output spm_rd_data
  );
endinterface

// File: rtl/spm_arbiter.sv
// Round-robin arbiter sharing one single-port scratch-pad memory between an
// instruction-fetch (read-only) requester and a data-memory requester.
`timescale 1ns/1ps
module spm_arbiter #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  spm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PEND_IF  = 2'd1,
    ST_PEND_MEM = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  state_e            state_q, state_d;
  owner_e            last_grant_q, last_grant_d;
  logic              pend_rd_q, pend_rd_d;
  logic [DATA_W-1:0] if_rd_q, if_rd_d;
  logic [DATA_W-1:0] mem_rd_q, mem_rd_d;

  logic              req_if_c, req_mem_c;
  logic              grant_if_c, grant_mem_c;

  logic [ADDR_W-1:0] spm_addr_c;
  logic              spm_as_c;
  logic              spm_rw_c;
  logic [DATA_W-1:0] spm_wr_data_c;

  // Arbitration: a lone requester always wins; on conflict the one not served last wins.
  always_comb begin
    req_if_c    = ~bus.if_as_;
    req_mem_c   = ~bus.mem_as_;
    grant_if_c  = ~reset & req_if_c  & (~req_mem_c | (last_grant_q == OWN_MEM));
    grant_mem_c = ~reset & req_mem_c & (~req_if_c  | (last_grant_q == OWN_IF));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWN_MEM;
      pend_rd_q    <= 1'b1;
      if_rd_q      <= '0;
      mem_rd_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pend_rd_q    <= pend_rd_d;
      if_rd_q      <= if_rd_d;
      mem_rd_q     <= mem_rd_d;
    end
  end

  // Next state, SPM drive and read-data capture.
  always_comb begin
    state_d       = ST_IDLE;
    last_grant_d  = last_grant_q;
    pend_rd_d     = pend_rd_q;
    if_rd_d       = if_rd_q;
    mem_rd_d      = mem_rd_q;
    spm_as_c      = 1'b1;
    spm_rw_c      = 1'b1;
    spm_addr_c    = '0;
    spm_wr_data_c = '0;

    if (grant_if_c) begin
      state_d      = ST_PEND_IF;
      last_grant_d = OWN_IF;
      pend_rd_d    = 1'b1;
      spm_as_c     = 1'b0;
      spm_addr_c   = bus.if_addr;
    end else if (grant_mem_c) begin
      state_d       = ST_PEND_MEM;
      last_grant_d  = OWN_MEM;
      pend_rd_d     = bus.mem_rw;
      spm_as_c      = 1'b0;
      spm_rw_c      = bus.mem_rw;
      spm_addr_c    = bus.mem_addr;
      spm_wr_data_c = bus.mem_wr_data;
    end

    // SPM read data is valid in the cycle after the grant; capture it for the owner.
    case (state_q)
      ST_PEND_IF:  if_rd_d = bus.spm_rd_data;
      ST_PEND_MEM: if (pend_rd_q) mem_rd_d = bus.spm_rd_data;
      default:     ;
    endcase
  end

  assign bus.spm_as_     = spm_as_c;
  assign bus.spm_rw      = spm_rw_c;
  assign bus.spm_addr    = spm_addr_c;
  assign bus.spm_wr_data = spm_wr_data_c;

  assign bus.if_busy     = req_if_c  & ~grant_if_c;
  assign bus.mem_busy    = req_mem_c & ~grant_mem_c;

  assign bus.if_rdy      = (state_q == ST_PEND_IF);
  assign bus.mem_rdy     = (state_q == ST_PEND_MEM);

  // Read data passes through in the rdy cycle, then holds from the capture flop.
  assign bus.if_rd_data  = if_rd_d;
  assign bus.mem_rd_data = mem_rd_d;

endmodule

// File: tb/tb_spm_arbiter.sv
// Bench for spm_arbiter: directed cycle table, then randomized traffic
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_spm_arbiter;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RAND_CYCLES = 600;

  typedef struct packed {
    logic              spm_as_;
    logic              spm_rw;
    logic [ADDR_W-1:0] spm_addr;
    logic [DATA_W-1:0] spm_wd;
    logic              if_busy;
    logic              mem_busy;
    logic              if_rdy;
    logic              mem_rdy;
    logic [DATA_W-1:0] if_rd;
    logic [DATA_W-1:0] mem_rd;
  } exp_t;

  typedef struct packed {
    logic              rst;
    logic              if_as_;
    logic [ADDR_W-1:0] if_addr;
    logic              mem_as_;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_wd;
    exp_t              e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic spm_init;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [DATA_W-1:0] init_word(input logic [7:0] a);
    case (a)
      8'h10:   init_word = 32'hDEADBEEF;
      8'h04:   init_word = 32'h0000_0044;
      8'h20:   init_word = 32'h0000_0001;
      8'h21:   init_word = 32'h0000_0002;
      default: init_word = {a, ~a, a ^ 8'h5A, 8'hC3};
    endcase
  endfunction

  // SPM macro model: single port, read data one cycle after the access.
  logic [DATA_W-1:0] spm_mem [256];
  always @(posedge clk) begin
    if (spm_init) begin
      for (int i = 0; i < 256; i++) spm_mem[i] <= init_word(8'(i));
      bus.spm_rd_data <= '0;
    end else if (!bus.spm_as_) begin
      if (bus.spm_rw) bus.spm_rd_data <= spm_mem[bus.spm_addr[7:0]];
      else            spm_mem[bus.spm_addr[7:0]] <= bus.spm_wr_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("spm_as_",     64'(bus.spm_as_),     64'(e.spm_as_));
    chk("spm_rw",      64'(bus.spm_rw),      64'(e.spm_rw));
    chk("spm_addr",    64'(bus.spm_addr),    64'(e.spm_addr));
    chk("spm_wr_data", 64'(bus.spm_wr_data), 64'(e.spm_wd));
    chk("if_busy",     64'(bus.if_busy),     64'(e.if_busy));
    chk("mem_busy",    64'(bus.mem_busy),    64'(e.mem_busy));
    chk("if_rdy",      64'(bus.if_rdy),      64'(e.if_rdy));
    chk("mem_rdy",     64'(bus.mem_rdy),     64'(e.mem_rdy));
    chk("if_rd_data",  64'(bus.if_rd_data),  64'(e.if_rd));
    chk("mem_rd_data", 64'(bus.mem_rd_data), 64'(e.mem_rd));
  endtask

  function automatic exp_t ex(input logic as_, input logic rw, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] wd, input logic ib, input logic mb,
                              input logic ir, input logic mr, input logic [DATA_W-1:0] ird,
                              input logic [DATA_W-1:0] mrd);
    ex = '{spm_as_: as_, spm_rw: rw, spm_addr: a, spm_wd: wd, if_busy: ib, mem_busy: mb,
           if_rdy: ir, mem_rdy: mr, if_rd: ird, mem_rd: mrd};
  endfunction

  function automatic vec_t row(input logic rst, input logic ias, input logic [ADDR_W-1:0] ia,
                               input logic mas, input logic [ADDR_W-1:0] ma, input logic rw,
                               input logic [DATA_W-1:0] wd, input exp_t e);
    row = '{rst: rst, if_as_: ias, if_addr: ia, mem_as_: mas, mem_addr: ma,
            mem_rw: rw, mem_wd: wd, e: e};
  endfunction

  task automatic drive(input logic ias, input logic [ADDR_W-1:0] ia, input logic mas,
                       input logic [ADDR_W-1:0] ma, input logic rw, input logic [DATA_W-1:0] wd);
    bus.if_as_      = ias;
    bus.if_addr     = ia;
    bus.mem_as_     = mas;
    bus.mem_addr    = ma;
    bus.mem_rw      = rw;
    bus.mem_wr_data = wd;
  endtask

  vec_t vq[$];

  // reference model state
  logic [DATA_W-1:0] ref_mem [256];
  int                m_pend;       // 0 none, 1 IF, 2 MEM
  logic              m_lg_mem;     // last grant was MEM
  logic              m_pend_rd;
  logic [DATA_W-1:0] m_pend_data;
  logic [DATA_W-1:0] m_if_hold, m_mem_hold;

  initial begin : main
    localparam logic [DATA_W-1:0] DB = 32'hDEADBEEF;
    localparam logic [ADDR_W-1:0] A0 = '0;
    localparam logic [DATA_W-1:0] D0 = '0;
    exp_t e;
    int   w;
    logic rq_if, rq_mem;

    reset    = 1'b1;
    spm_init = 1'b1;
    drive(1'b1, A0, 1'b1, A0, 1'b1, D0);
    repeat (2) @(posedge clk);
    #1 spm_init = 1'b0;

    // directed cycle table: inputs of the cycle and outputs expected in that cycle
    vq.push_back(row(1'b0, 1'b1, A0, 1'b1, A0, 1'b1, D0, ex(1'b1,1'b1,A0,D0, 1'b0,1'b0, 1'b0,1'b0, D0,D0)));
    // IF-only read of 0x10
    vq.push_back(row(1'b0, 1'b0, 30'h10, 1'b1, A0, 1'b1, D0, ex(1'b0,1'b1,30'h10,D0, 1'b0,1'b0, 1'b0,1'b0, D0,D0)));
    vq.push_back(row(1'b0, 1'b1, A0, 1'b1, A0, 1'b1, D0, ex(1'b1,1'b1,A0,D0, 1'b0,1'b0, 1'b1,1'b0, DB,D0)));
    // reset, then first conflict: IF read 0x4 vs MEM write 0x8/0x55
    vq.push_back(row(1'b1, 1'b1, A0, 1'b1, A0, 1'b1, D0, ex(1'b1,1'b1,A0,D0, 1'b0,1'b0, 1'b0,1'b0, D0,D0)));
    vq.push_back(row(1'b0, 1'b0, 30'h4, 1'b0, 30'h8, 1'b0, 32'h55, ex(1'b0,1'b1,30'h4,D0, 1'b0,1'b1, 1'b0,1'b0, D0,D0)));
    vq.push_back(row(1'b0, 1'b1, A0, 1'b0, 30'h8, 1'b0, 32'h55, ex(1'b0,1'b0,30'h8,32'h55, 1'b0,1'b0, 1'b1,1'b0, 32'h44,D0)));
    vq.push_back(row(1'b0, 1'b1, A0, 1'b1, A0, 1'b1, D0, ex(1'b1,1'b1,A0,D0, 1'b0,1'b0, 1'b0,1'b1, 32'h44,D0)));
    // sustained conflict, six cycles
    vq.push_back(row(1'b0, 1'b0, 30'h10, 1'b0, 30'h20, 1'b1, D0, ex(1'b0,1'b1,30'h10,D0, 1'b0,1'b1, 1'b0,1'b0, 32'h44,D0)));
    vq.push_back(row(1'b0, 1'b0, 30'h10, 1'b0, 30'h20, 1'b1, D0, ex(1'b0,1'b1,30'h20,D0, 1'b1,1'b0, 1'b1,1'b0, DB,D0)));
    vq.push_back(row(1'b0, 1'b0, 30'h10, 1'b0, 30'h20, 1'b1, D0, ex(1'b0,1'b1,30'h10,D0, 1'b0,1'b1, 1'b0,1'b1, DB,32'h1)));
    vq.push_back(row(1'b0, 1'b0, 30'h10, 1'b0, 30'h20, 1'b1, D0, ex(1'b0,1'b1,30'h20,D0, 1'b1,1'b0, 1'b1,1'b0, DB,32'h1)));
    vq.push_back(row(1'b0, 1'b0, 30'h10, 1'b0, 30'h20, 1'b1, D0, ex(1'b0,1'b1,30'h10,D0, 1'b0,1'b1, 1'b0,1'b1, DB,32'h1)));
    vq.push_back(row(1'b0, 1'b0, 30'h10, 1'b0, 30'h20, 1'b1, D0, ex(1'b0,1'b1,30'h20,D0, 1'b1,1'b0, 1'b1,1'b0, DB,32'h1)));
    vq.push_back(row(1'b0, 1'b1, A0, 1'b1, A0, 1'b1, D0, ex(1'b1,1'b1,A0,D0, 1'b0,1'b0, 1'b0,1'b1, DB,32'h1)));
    // back-to-back MEM reads 0x20, 0x21
    vq.push_back(row(1'b0, 1'b1, A0, 1'b0, 30'h20, 1'b1, D0, ex(1'b0,1'b1,30'h20,D0, 1'b0,1'b0, 1'b0,1'b0, DB,32'h1)));
    vq.push_back(row(1'b0, 1'b1, A0, 1'b0, 30'h21, 1'b1, D0, ex(1'b0,1'b1,30'h21,D0, 1'b0,1'b0, 1'b0,1'b1, DB,32'h1)));
    vq.push_back(row(1'b0, 1'b1, A0, 1'b1, A0, 1'b1, D0, ex(1'b1,1'b1,A0,D0, 1'b0,1'b0, 1'b0,1'b1, DB,32'h2)));
    // MEM write keeps the previous read data, then read it back
    vq.push_back(row(1'b0, 1'b1, A0, 1'b0, 30'h30, 1'b0, 32'h99, ex(1'b0,1'b0,30'h30,32'h99, 1'b0,1'b0, 1'b0,1'b0, DB,32'h2)));
    vq.push_back(row(1'b0, 1'b1, A0, 1'b1, A0, 1'b1, D0, ex(1'b1,1'b1,A0,D0, 1'b0,1'b0, 1'b0,1'b1, DB,32'h2)));
    vq.push_back(row(1'b0, 1'b1, A0, 1'b0, 30'h30, 1'b1, D0, ex(1'b0,1'b1,30'h30,D0, 1'b0,1'b0, 1'b0,1'b0, DB,32'h2)));
    vq.push_back(row(1'b0, 1'b1, A0, 1'b1, A0, 1'b1, D0, ex(1'b1,1'b1,A0,D0, 1'b0,1'b0, 1'b0,1'b1, DB,32'h99)));
    // reset in the cycle after a MEM read grant
    vq.push_back(row(1'b0, 1'b1, A0, 1'b0, 30'h21, 1'b1, D0, ex(1'b0,1'b1,30'h21,D0, 1'b0,1'b0, 1'b0,1'b0, DB,32'h99)));
    vq.push_back(row(1'b1, 1'b1, A0, 1'b1, A0, 1'b1, D0, ex(1'b1,1'b1,A0,D0, 1'b0,1'b0, 1'b0,1'b0, D0,D0)));
    vq.push_back(row(1'b0, 1'b1, A0, 1'b1, A0, 1'b1, D0, ex(1'b1,1'b1,A0,D0, 1'b0,1'b0, 1'b0,1'b0, D0,D0)));
    vq.push_back(row(1'b0, 1'b0, 30'h4, 1'b1, A0, 1'b1, D0, ex(1'b0,1'b1,30'h4,D0, 1'b0,1'b0, 1'b0,1'b0, D0,D0)));
    vq.push_back(row(1'b0, 1'b1, A0, 1'b1, A0, 1'b1, D0, ex(1'b1,1'b1,A0,D0, 1'b0,1'b0, 1'b1,1'b0, 32'h44,D0)));
    // IF loses the conflict and withdraws while busy: no IF access, no if_rdy
    vq.push_back(row(1'b0, 1'b0, 30'h10, 1'b0, 30'h20, 1'b1, D0, ex(1'b0,1'b1,30'h20,D0, 1'b1,1'b0, 1'b0,1'b0, 32'h44,D0)));
    vq.push_back(row(1'b0, 1'b1, A0, 1'b1, A0, 1'b1, D0, ex(1'b1,1'b1,A0,D0, 1'b0,1'b0, 1'b0,1'b1, 32'h44,32'h1)));
    vq.push_back(row(1'b0, 1'b1, A0, 1'b1, A0, 1'b1, D0, ex(1'b1,1'b1,A0,D0, 1'b0,1'b0, 1'b0,1'b0, 32'h44,32'h1)));

    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      reset = vq[i].rst;
      drive(vq[i].if_as_, vq[i].if_addr, vq[i].mem_as_, vq[i].mem_addr, vq[i].mem_rw, vq[i].mem_wd);
      @(negedge clk);
      check_all(vq[i].e);
    end

    // randomized traffic on addresses 0x40..0x4F, untouched by the table
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    m_pend = 0; m_lg_mem = 1'b1; m_pend_rd = 1'b1;
    m_pend_data = '0; m_if_hold = '0; m_mem_hold = '0;

    for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
      @(posedge clk);
      #1;
      reset = (cyc == 0) || ($urandom_range(0, 49) == 0);
      drive(($urandom_range(0, 2) == 0), ADDR_W'(32'h40 + $urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0), ADDR_W'(32'h40 + $urandom_range(0, 15)),
            1'(($urandom_range(0, 1))), DATA_W'($urandom));
      @(negedge clk);

      if (reset) begin
        m_pend = 0; m_lg_mem = 1'b1; m_if_hold = '0; m_mem_hold = '0;
      end
      // completion of last cycle's access
      if (m_pend == 1) m_if_hold = m_pend_data;
      if (m_pend == 2 && m_pend_rd) m_mem_hold = m_pend_data;

      rq_if  = !bus.if_as_;
      rq_mem = !bus.mem_as_;
      w = 0;
      if (!reset) begin
        if (rq_if && rq_mem) w = m_lg_mem ? 1 : 2;
        else if (rq_if)      w = 1;
        else if (rq_mem)     w = 2;
      end

      e.spm_as_  = (w == 0);
      e.spm_rw   = (w == 2) ? bus.mem_rw : 1'b1;
      e.spm_addr = (w == 1) ? bus.if_addr : (w == 2) ? bus.mem_addr : '0;
      e.spm_wd   = (w == 2) ? bus.mem_wr_data : '0;
      e.if_busy  = rq_if  && (w != 1);
      e.mem_busy = rq_mem && (w != 2);
      e.if_rdy   = (m_pend == 1);
      e.mem_rdy  = (m_pend == 2);
      e.if_rd    = m_if_hold;
      e.mem_rd   = m_mem_hold;
      check_all(e);

      m_pend = w;
      if (w == 1) begin
        m_lg_mem    = 1'b0;
        m_pend_rd   = 1'b1;
        m_pend_data = ref_mem[bus.if_addr[7:0]];
      end else if (w == 2) begin
        m_lg_mem  = 1'b1;
        m_pend_rd = bus.mem_rw;
        if (bus.mem_rw) m_pend_data = ref_mem[bus.mem_addr[7:0]];
        else            ref_mem[bus.mem_addr[7:0]] = bus.mem_wr_data;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spm_arbiter.md
SPM_ARBITER -- requirements
Module: spm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, word-data width.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port if_as_  input  1  IF requester address strobe, active-low.
REQ-006 SHALL have port if_addr  input  ADDR_W  IF word address.
REQ-007 SHALL have port if_rd_data  output  DATA_W  IF read data.
REQ-008 SHALL have port if_rdy  output  1  IF access complete pulse.
REQ-009 SHALL have port if_busy  output  1  IF request not granted this cycle; hold request.
REQ-010 SHALL have port mem_as_  input  1  MEM requester address strobe, active-low.
REQ-011 SHALL have port mem_addr  input  ADDR_W  MEM word address.
REQ-012 SHALL have port mem_rw  input  1  MEM direction: 1 = read, 0 = write.
REQ-013 SHALL have port mem_wr_data  input  DATA_W  MEM write data.
REQ-014 SHALL have port mem_rd_data  output  DATA_W  MEM read data.
REQ-015 SHALL have port mem_rdy  output  1  MEM access complete pulse.
REQ-016 SHALL have port mem_busy  output  1  MEM request not granted this cycle; hold request.
REQ-017 SHALL have ports spm_addr (output, ADDR_W), spm_as_ (output, 1, active-low), spm_rw (output, 1), spm_wr_data (output, DATA_W), and spm_rd_data (input, DATA_W), forming a single-port SPM with one-cycle synchronous read latency.

Function
REQ-018 SHALL drive spm_* combinationally from the granted requester in the same cycle as the grant; with no grant, SHALL drive spm_as_=1, spm_rw=1, spm_addr=0, spm_wr_data=0.
REQ-019 SHALL grant the only requester when exactly one strobe is low.
REQ-020 SHALL, when both strobes are low, grant the requester opposite to register last_grant (round-robin).
REQ-021 SHALL update last_grant at each clock edge on which a grant occurred, and hold it otherwise.
REQ-022 SHALL drive busy=1 combinationally to a requesting-but-not-granted requester, and busy=0 otherwise.
REQ-023 SHALL always drive IF accesses as reads (spm_rw=1); if_wr data does not exist.
REQ-024 SHALL register the grant owner and direction into a pending state (IDLE, PEND_IF, PEND_MEM), entered on any granted cycle and left after one cycle unless a new grant occurs.
REQ-025 SHALL assert the owner's rdy for exactly one cycle, the cycle after the grant, for both reads and writes.
REQ-026 SHALL, on a read completion, drive the owner's rd_data = spm_rd_data in the rdy cycle and hold it until that owner's next read completion; the non-owner's rd_data SHALL be unchanged.
REQ-027 SHALL support back-to-back grants: a new grant in the rdy cycle of the previous access is legal, giving one access per cycle.
REQ-028 SHALL produce no rdy and no SPM access for a strobe withdrawn while busy=1.
REQ-029 SHALL bound starvation: under continuous dual requests, each requester is granted at least every 2nd cycle.

Reset
REQ-030 SHALL, while reset=1: last_grant=MEM (IF wins the first conflict), state=IDLE, if_rdy=mem_rdy=0, if_rd_data=mem_rd_data=0, spm_as_=1.
REQ-031 SHALL, on reset asserted mid-access, drop the pending access; no rdy is produced after reset deasserts.
REQ-032 SHALL accept requests on the first rising edge after reset deasserts.

Verification
REQ-033 SHALL cover IF-only read: if_addr=0x10, SPM returns 0xDEADBEEF -> spm_as_=0 in cycle 0; if_rdy=1 and if_rd_data=0xDEADBEEF in cycle 1; if_busy stays 0.
REQ-034 SHALL cover a first conflict after reset: IF read 0x4 and MEM write 0x8/0x55 -> cycle 0 grants IF with mem_busy=1; cycle 1 grants MEM write (spm_rw=0, spm_wr_data=0x55) with if_rdy=1; cycle 2 mem_rdy=1.
REQ-035 SHALL cover sustained conflict for 6 cycles -> grants alternate IF, MEM, IF, MEM, IF, MEM; each rdy pulses 3 times.
REQ-036 SHALL cover back-to-back MEM reads of 0x20 then 0x21 (data 0x1, 0x2) -> mem_rdy=1 in cycles 1 and 2 with mem_rd_data 0x1 then 0x2.
REQ-037 SHALL cover reset asserted in the cycle after a MEM read grant -> mem_rdy stays 0, mem_rd_data=0, and spm_as_=1 until the next request.
REQ-038 SHALL cover a MEM write completion -> mem_rd_data holds its prior read value.
